// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared widths, FSM states and slot commands for the voice allocator
package voice_allocator_pkg;
  localparam int OSC_VOICES = 4;
  localparam int NOTE_W = 7;
  localparam int VEL_W = 7;
  localparam int AGE_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_ASSIGN, CMD_RELEASE, CMD_AGE_INC, CMD_CLEAR} slot_cmd_t;
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return &a ? a : a + 1'b1;
  endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: MIDI event handshake in, per-slot oscillator controls out
interface voice_allocator_if #(
  parameter int VOICES = voice_allocator_pkg::OSC_VOICES,
  parameter int NOTE_W = voice_allocator_pkg::NOTE_W
) ();
  logic evt_valid_i;
  logic evt_ready_o;
  logic evt_on_i;
  logic [NOTE_W-1:0] evt_note_i;
  logic [voice_allocator_pkg::VEL_W-1:0] evt_vel_i;
  logic panic_i;
  logic [VOICES*NOTE_W-1:0] voice_note_o;
  logic [VOICES-1:0] voice_gate_o;
  logic [VOICES-1:0] voice_load_o;
  logic steal_o;
  modport master (
    output evt_valid_i, evt_on_i, evt_note_i, evt_vel_i, panic_i,
    input evt_ready_o, voice_note_o, voice_gate_o, voice_load_o, steal_o
  );
  modport slave (
    input evt_valid_i, evt_on_i, evt_note_i, evt_vel_i, panic_i,
    output evt_ready_o, voice_note_o, voice_gate_o, voice_load_o, steal_o
  );
endinterface

// File: rtl/voice_slot.sv
// voice_slot: one oscillator slot holding note, gate and saturating age
module voice_slot import voice_allocator_pkg::*; (
  input  logic              clk_i,
  input  logic              rst_i,
  input  slot_cmd_t         cmd_i,
  input  logic [NOTE_W-1:0] note_i,
  output logic [NOTE_W-1:0] note_o,
  output logic              gate_o,
  output logic [AGE_W-1:0]  age_o
);
  logic [NOTE_W-1:0] note_q, note_d;
  logic gate_q, gate_d;
  logic [AGE_W-1:0] age_q, age_d;
  // released or cleared slots keep their note; only sounding slots age
  always_comb begin
    note_d = cmd_i == CMD_ASSIGN ? note_i : note_q;
    gate_d = cmd_i == CMD_ASSIGN ? 1'b1 : (cmd_i == CMD_RELEASE || cmd_i == CMD_CLEAR) ? 1'b0 : gate_q;
    age_d = (cmd_i == CMD_ASSIGN || cmd_i == CMD_CLEAR) ? '0 : (cmd_i == CMD_AGE_INC && gate_q) ? age_inc(age_q) : age_q;
  end
  // slot state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      note_q <= '0;
      gate_q <= 1'b0;
      age_q <= '0;
    end else begin
      note_q <= note_d;
      gate_q <= gate_d;
      age_q <= age_d;
    end
  end
  assign note_o = note_q;
  assign gate_o = gate_q;
  assign age_o = age_q;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: scans slots one per cycle, then retriggers, assigns or steals a voice
module voice_allocator import voice_allocator_pkg::*; #(
  parameter int VOICES = OSC_VOICES
) (
  input logic clk_i,
  input logic rst_i,
  voice_allocator_if.slave bus
);
  localparam int IW = VOICES > 1 ? $clog2(VOICES) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, match_q, match_d, free_q, free_d, old_q, old_d;
  logic match_ok_q, match_ok_d, free_ok_q, free_ok_d, old_ok_q, old_ok_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;
  logic on_q, on_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [VOICES-1:0] load_q, load_d;
  logic steal_q, steal_d;
  slot_cmd_t cmd [VOICES];
  logic [NOTE_W-1:0] s_note [VOICES];
  logic [AGE_W-1:0] s_age [VOICES];
  logic [VOICES-1:0] s_gate;
  logic [IW-1:0] tgt;
  genvar k;
  generate
    for (k = 0; k < VOICES; k++) begin : g_slot
      voice_slot u_slot (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_i(cmd[k]), .note_i(note_q),
        .note_o(s_note[k]), .gate_o(s_gate[k]), .age_o(s_age[k])
      );
      assign bus.voice_note_o[k*NOTE_W +: NOTE_W] = s_note[k];
    end
  endgenerate
  assign bus.voice_gate_o = s_gate;
  assign bus.voice_load_o = load_q;
  assign bus.steal_o = steal_q;
  assign bus.evt_ready_o = state_q == ST_IDLE && !bus.panic_i;
  assign tgt = match_ok_q ? match_q : free_ok_q ? free_q : old_q;
  // FSM next state, scan trackers and the slot commands issued at commit; panic overrides all
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    match_d = match_q;
    match_ok_d = match_ok_q;
    free_d = free_q;
    free_ok_d = free_ok_q;
    old_d = old_q;
    old_ok_d = old_ok_q;
    old_age_d = old_age_q;
    on_d = on_q;
    note_d = note_q;
    load_d = '0;
    steal_d = 1'b0;
    for (int i = 0; i < VOICES; i++) cmd[i] = CMD_NONE;
    if (bus.panic_i) begin
      state_d = ST_IDLE;
      for (int i = 0; i < VOICES; i++) cmd[i] = CMD_CLEAR;
    end else if (state_q == ST_IDLE) begin
      if (bus.evt_valid_i) begin
        state_d = ST_SCAN;
        idx_d = '0;
        on_d = bus.evt_on_i && |bus.evt_vel_i;
        note_d = bus.evt_note_i;
        match_ok_d = 1'b0;
        free_ok_d = 1'b0;
        old_ok_d = 1'b0;
      end
    end else if (state_q == ST_SCAN) begin
      idx_d = idx_q + 1'b1;
      state_d = idx_q == IW'(VOICES - 1) ? ST_COMMIT : ST_SCAN;
      if (!match_ok_q && s_gate[idx_q] && s_note[idx_q] == note_q) begin
        match_ok_d = 1'b1;
        match_d = idx_q;
      end
      if (!free_ok_q && !s_gate[idx_q]) begin
        free_ok_d = 1'b1;
        free_d = idx_q;
      end
      if (s_gate[idx_q] && (!old_ok_q || s_age[idx_q] > old_age_q)) begin
        old_ok_d = 1'b1;
        old_d = idx_q;
        old_age_d = s_age[idx_q];
      end
    end else begin
      state_d = ST_IDLE;
      if (on_q) begin
        for (int i = 0; i < VOICES; i++) cmd[i] = IW'(i) == tgt ? CMD_ASSIGN : CMD_AGE_INC;
        load_d = VOICES'(1) << tgt;
        steal_d = !match_ok_q && !free_ok_q;
      end else if (match_ok_q) begin
        cmd[match_q] = CMD_RELEASE;
      end
    end
  end
  // FSM, latched event, trackers and registered strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      match_q <= '0;
      match_ok_q <= 1'b0;
      free_q <= '0;
      free_ok_q <= 1'b0;
      old_q <= '0;
      old_ok_q <= 1'b0;
      old_age_q <= '0;
      on_q <= 1'b0;
      note_q <= '0;
      load_q <= '0;
      steal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      match_q <= match_d;
      match_ok_q <= match_ok_d;
      free_q <= free_d;
      free_ok_q <= free_ok_d;
      old_q <= old_d;
      old_ok_q <= old_ok_d;
      old_age_q <= old_age_d;
      on_q <= on_d;
      note_q <= note_d;
      load_q <= load_d;
      steal_q <= steal_d;
    end
  end
endmodule
